// File: rtl/rps_pkg.sv
// Shared choice/mode encodings, controller state encoding and the win rule
// for the rock-paper-scissors round controller.
package rps_pkg;

   localparam logic [1:0] ROCK    = 2'b00;
   localparam logic [1:0] SCISSOR = 2'b01;
   localparam logic [1:0] PAPER   = 2'b10;
   localparam logic [1:0] INVALID = 2'b11;

   localparam logic [1:0] MODE_RANDOM    = 2'b00;
   localparam logic [1:0] MODE_MARKOV    = 2'b01;
   localparam logic [1:0] MODE_REINFORCE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_LATCH    = 3'd2,
      ST_JUDGE    = 3'd3,
      ST_DRAW     = 3'd4,
      ST_RELEASE  = 3'd5
   } state_e;

   // True when choice a defeats choice b.
   function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
      return (a == ROCK    && b == SCISSOR) ||
             (a == SCISSOR && b == PAPER)   ||
             (a == PAPER   && b == ROCK);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Start-key conditioner: 2-flop synchroniser followed by a counter debouncer.
// level = debounced "key held", press = one-cycle pulse on the debounced press.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             key_held;

   assign key_held = ~sync2_q;

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (key_held != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = key_held;
            press_d = key_held;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/rps_round_controller.sv
// Runs one rock-paper-scissors round per debounced start press: wait for the
// computer player, latch choices, judge and score, then trigger the redraw.
module rps_round_controller
   import rps_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned READY_TIMEOUT   = 50000000,
   parameter int unsigned SCORE_W         = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start_n,
   input  logic [1:0]         mode,
   input  logic [1:0]         user,
   input  logic [1:0]         com_ra,
   input  logic [1:0]         com_m,
   input  logic [1:0]         com_re,
   input  logic               re_ready,
   input  logic               draw_done,
   output logic [1:0]         com_loaded,
   output logic [1:0]         user_loaded,
   output logic [SCORE_W-1:0] user_score,
   output logic [SCORE_W-1:0] com_score,
   output logic               uwin,
   output logic               cwin,
   output logic               equ,
   output logic               learn_valid,
   output logic [1:0]         learn_user,
   output logic               draw_start,
   output logic               err,
   output logic               busy
);

   localparam int unsigned TMO_W = $clog2(READY_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(READY_TIMEOUT - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic key_level, key_press;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n   (start_n),
      .level   (key_level),
      .press   (key_press)
   );

   state_e             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [1:0]         com_loaded_q, com_loaded_d;
   logic [1:0]         user_loaded_q, user_loaded_d;
   logic [SCORE_W-1:0] user_score_q, user_score_d;
   logic [SCORE_W-1:0] com_score_q, com_score_d;
   logic               uwin_q, uwin_d, cwin_q, cwin_d, equ_q, equ_d;
   logic               learn_valid_q, learn_valid_d;
   logic [1:0]         learn_user_q, learn_user_d;
   logic               draw_start_q, draw_start_d;
   logic               draw_pend_q, draw_pend_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic [1:0]         sel_choice_c;

   always_comb begin
      case (mode_q)
         MODE_MARKOV:    sel_choice_c = com_m;
         MODE_REINFORCE: sel_choice_c = com_re;
         default:        sel_choice_c = com_ra;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      tmo_d         = tmo_q;
      com_loaded_d  = com_loaded_q;
      user_loaded_d = user_loaded_q;
      user_score_d  = user_score_q;
      com_score_d   = com_score_q;
      uwin_d        = uwin_q;
      cwin_d        = cwin_q;
      equ_d         = equ_q;
      learn_valid_d = 1'b0;
      learn_user_d  = learn_user_q;
      draw_start_d  = 1'b0;
      draw_pend_d   = draw_pend_q;
      err_d         = err_q;

      case (state_q)
         ST_IDLE: begin
            if (key_press) begin
               if (user == INVALID) begin
                  err_d   = 1'b1;
                  uwin_d  = 1'b0;
                  cwin_d  = 1'b0;
                  equ_d   = 1'b0;
                  state_d = ST_RELEASE;
               end else begin
                  mode_d  = mode;
                  err_d   = 1'b0;
                  tmo_d   = '0;
                  state_d = ST_WAIT_RDY;
               end
            end
         end
         ST_WAIT_RDY: begin
            if (mode_q != MODE_REINFORCE || re_ready) begin
               state_d = ST_LATCH;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_RELEASE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_LATCH: begin
            // An invalid user choice here would break the one-hot judge, so abort too.
            if (sel_choice_c == INVALID || user == INVALID) begin
               err_d   = 1'b1;
               state_d = ST_RELEASE;
            end else begin
               com_loaded_d  = sel_choice_c;
               user_loaded_d = user;
               state_d       = ST_JUDGE;
            end
         end
         ST_JUDGE: begin
            uwin_d = 1'b0;
            cwin_d = 1'b0;
            equ_d  = 1'b0;
            if (user_loaded_q == com_loaded_q) begin
               equ_d = 1'b1;
            end else if (beats(user_loaded_q, com_loaded_q)) begin
               uwin_d = 1'b1;
               if (user_score_q != SCORE_MAX) user_score_d = user_score_q + SCORE_W'(1);
            end else begin
               cwin_d = 1'b1;
               if (com_score_q != SCORE_MAX) com_score_d = com_score_q + SCORE_W'(1);
            end
            learn_valid_d = 1'b1;
            learn_user_d  = user_loaded_q;
            draw_pend_d   = 1'b1;
            state_d       = ST_DRAW;
         end
         ST_DRAW: begin
            // draw_done counts from the cycle draw_start is visible onwards.
            if (draw_pend_q) begin
               draw_start_d = 1'b1;
               draw_pend_d  = 1'b0;
            end else if (draw_done) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!key_level) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         mode_q        <= '0;
         tmo_q         <= '0;
         com_loaded_q  <= '0;
         user_loaded_q <= '0;
         user_score_q  <= '0;
         com_score_q   <= '0;
         uwin_q        <= 1'b0;
         cwin_q        <= 1'b0;
         equ_q         <= 1'b0;
         learn_valid_q <= 1'b0;
         learn_user_q  <= '0;
         draw_start_q  <= 1'b0;
         draw_pend_q   <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         tmo_q         <= tmo_d;
         com_loaded_q  <= com_loaded_d;
         user_loaded_q <= user_loaded_d;
         user_score_q  <= user_score_d;
         com_score_q   <= com_score_d;
         uwin_q        <= uwin_d;
         cwin_q        <= cwin_d;
         equ_q         <= equ_d;
         learn_valid_q <= learn_valid_d;
         learn_user_q  <= learn_user_d;
         draw_start_q  <= draw_start_d;
         draw_pend_q   <= draw_pend_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
      end
   end

   assign com_loaded  = com_loaded_q;
   assign user_loaded = user_loaded_q;
   assign user_score  = user_score_q;
   assign com_score   = com_score_q;
   assign uwin        = uwin_q;
   assign cwin        = cwin_q;
   assign equ         = equ_q;
   assign learn_valid = learn_valid_q;
   assign learn_user  = learn_user_q;
   assign draw_start  = draw_start_q;
   assign err         = err_q;
   assign busy        = busy_q;

endmodule
